// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, FSM state type and divide corner constants
// for div_ctrl and div_result_cache.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

endpackage

// File: rtl/div_result_cache.sv
// div_result_cache: one-entry memo of the last divider result.
// Ports: wr_* write port, lk_* lookup, hit/hit_q/hit_rem result.
module div_result_cache
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_a,
  input  logic [31:0] wr_b,
  input  logic        wr_signed,
  input  logic [31:0] wr_q,
  input  logic [31:0] wr_rem,
  input  logic [31:0] lk_a,
  input  logic [31:0] lk_b,
  input  logic        lk_signed,
  output logic        hit,
  output logic [31:0] hit_q,
  output logic [31:0] hit_rem
);

  logic        v_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        s_q;
  logic [31:0] q_q;
  logic [31:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_q <= 1'b0;
      q_q <= '0;
      r_q <= '0;
    end else if (wr_en) begin
      v_q <= 1'b1;
      a_q <= wr_a;
      b_q <= wr_b;
      s_q <= wr_signed;
      q_q <= wr_q;
      r_q <= wr_rem;
    end
  end

  assign hit = v_q
            && (lk_a == a_q)
            && (lk_b == b_q)
            && (lk_signed == s_q);
  assign hit_q   = q_q;
  assign hit_rem = r_q;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: request/response front end for an iterative divider; handles
// /0 and INT_MIN/-1 locally, flush, and (DIV_RESULT_CACHE_EN) a result memo.
module div_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_in_en,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_signed,
  input  logic             div_idle,
  input  logic             div_out_en,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_rem,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  state_t state;
  state_t state_nx;

  logic             rem_q;
  logic             sgn_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] tag_q;

  logic        acc;
  logic        req_sgn;
  logic        dz;
  logic        ovf;
  logic        hit;
  logic        fast;
  logic        cap;
  logic [31:0] hit_q;
  logic [31:0] hit_rem;
  logic [31:0] fast_res;

  assign req_ready = (state == IDLE) && !flush;
  assign acc       = req_valid && req_ready;
  assign req_sgn   = !req_op[0];
  assign dz        = (req_b == '0);
  assign ovf       = req_sgn
                  && (req_a == INT_MIN)
                  && (req_b == ALL_ONES);
  assign fast      = dz || ovf || hit;

  // Divider result that will be presented to the consumer.
  assign cap = (state == WAIT) && div_out_en && !flush;

`ifdef DIV_RESULT_CACHE_EN
  div_result_cache u_cache (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cap),
    .wr_a      (a_q),
    .wr_b      (b_q),
    .wr_signed (sgn_q),
    .wr_q      (div_q),
    .wr_rem    (div_rem),
    .lk_a      (req_a),
    .lk_b      (req_b),
    .lk_signed (req_sgn),
    .hit       (hit),
    .hit_q     (hit_q),
    .hit_rem   (hit_rem)
  );
`else
  assign hit     = 1'b0;
  assign hit_q   = '0;
  assign hit_rem = '0;
`endif

  // dz and ovf are exclusive: ovf needs b == all ones.
  always_comb begin
    fast_res = req_op[1] ? hit_rem : hit_q;
    unique case (1'b1)
      dz:      fast_res = req_op[1] ? req_a : ALL_ONES;
      ovf:     fast_res = req_op[1] ? '0 : INT_MIN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_in_en = 1'b0;
    case (state)
      IDLE: begin
        if (acc) state_nx = fast ? RESP : ISSUE;
      end
      ISSUE: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (div_idle) begin
          div_in_en = 1'b1;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        // A flush racing the result pulse has nothing left to drain.
        if (flush)           state_nx = div_out_en ? IDLE : DRAIN;
        else if (div_out_en) state_nx = RESP;
      end
      RESP: begin
        if (flush || resp_ready) state_nx = IDLE;
      end
      DRAIN: begin
        if (div_out_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= 1'b0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      res_q <= '0;
    end else begin
      if (acc) begin
        rem_q <= req_op[1];
        sgn_q <= req_sgn;
        a_q   <= req_a;
        b_q   <= req_b;
        tag_q <= req_tag;
        if (fast) res_q <= fast_res;
      end
      if (cap) res_q <= rem_q ? div_rem : div_q;
    end
  end

  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_signed = sgn_q;
  assign resp_valid = (state == RESP);
  assign resp_data  = res_q;
  assign resp_tag   = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a behavioural divider,
// a RISC-V divide reference model and a per-cycle response scoreboard.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [31:0]   req_a = '0;
  logic [31:0]   req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          div_in_en;
  logic [31:0]   div_a;
  logic [31:0]   div_b;
  logic          div_signed;
  logic          div_idle = 1'b1;
  logic          div_out_en = 1'b0;
  logic [31:0]   div_q = '0;
  logic [31:0]   div_rem = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_data;
  logic [TW-1:0] resp_tag;

  int   n_cmp = 0;
  int   n_err = 0;
  int   starts = 0;
  logic last_sgn = 1'b0;

  logic [31:0]   exp_d[$];
  logic [TW-1:0] exp_t[$];

  always #5 clk = ~clk;

  div_ctrl #(.TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .div_in_en  (div_in_en),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_signed (div_signed),
    .div_idle   (div_idle),
    .div_out_en (div_out_en),
    .div_q      (div_q),
    .div_rem    (div_rem),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  // RISC-V M-extension divide/remainder semantics.
  function automatic logic [31:0] ref_res(
    logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic void chk(
    string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Behavioural divider: fixed latency, one op at a time.
  initial begin : divider
    int          cnt;
    logic        st;
    logic        sg;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] pq;
    logic [31:0] pr;
    cnt = 0;
    pq = 0;
    pr = 0;
    forever begin
      @(negedge clk);
      st = div_in_en && rst_n;
      sg = div_signed;
      qa = div_a;
      qb = div_b;
      @(posedge clk);
      #1;
      div_out_en = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        div_idle = 1'b1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            div_out_en = 1'b1;
            div_q = pq;
            div_rem = pr;
            div_idle = 1'b1;
          end
        end
        if (st) begin
          starts++;
          last_sgn = sg;
          cnt = LAT;
          div_idle = 1'b0;
          pq = ref_res({1'b0, !sg}, qa, qb);
          pr = ref_res({1'b1, !sg}, qa, qb);
        end
      end
    end
  end

  // Scoreboard: compare every valid response, then track handshakes.
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (exp_d.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got data %h, none expected",
                   resp_data);
        end else begin
          chk("sb_data", resp_data, exp_d[0]);
          chk("sb_tag", 32'(resp_tag), 32'(exp_t[0]));
        end
        chk("sb_req_ready_low", 32'(req_ready), 0);
      end
      if (!rst_n || flush) begin
        exp_d.delete();
        exp_t.delete();
      end else begin
        if (resp_valid && resp_ready) begin
          void'(exp_d.pop_front());
          void'(exp_t.pop_front());
        end
        if (req_valid && req_ready) begin
          exp_d.push_back(ref_res(req_op, req_a, req_b));
          exp_t.push_back(req_tag);
        end
      end
    end
  end

  // Present a request until accepted; returns one cycle after acceptance.
  task automatic send(
    logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [TW-1:0] tag);
    bit ok;
    ok = 0;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
    req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no req_ready, expected accept");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for resp_valid; cyc counts negedges before it (0 = latency 1).
  task automatic get_resp(
    output logic [31:0] d, output logic [TW-1:0] t, output int cyc);
    bit ok;
    ok = 0;
    d = '0;
    t = '0;
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        d = resp_data;
        t = resp_tag;
        ok = 1;
        break;
      end
      cyc++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got no resp_valid, expected one");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0]   d;
    logic [TW-1:0] t;
    int            c;
    int            s0;
    bit            seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_div_in_en", 32'(div_in_en), 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    chk("rst_div_signed", 32'(div_signed), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", 32'(resp_tag), 0);
    step();
    rst_n = 1'b1;
    step();

    s0 = starts;
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd3);
    get_resp(d, t, c);
    chk("div_m7_2_data", d, 32'hFFFF_FFFD);
    chk("div_m7_2_tag", 32'(t), 3);
    chk("div_m7_2_starts", starts - s0, 1);
    chk("div_m7_2_signed", 32'(last_sgn), 1);
    step();

    s0 = starts;
    send(OP_REMU, 32'd5, 32'd0, 4'd1);
    get_resp(d, t, c);
    chk("remu_b0_data", d, 32'd5);
    chk("remu_b0_lat", c, 0);
    step();
    send(OP_DIVU, 32'd5, 32'd0, 4'd2);
    get_resp(d, t, c);
    chk("divu_b0_data", d, 32'hFFFF_FFFF);
    chk("divu_b0_lat", c, 0);
    chk("b0_starts", starts - s0, 0);
    step();

    s0 = starts;
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4);
    get_resp(d, t, c);
    chk("div_ovf_data", d, 32'h8000_0000);
    chk("div_ovf_lat", c, 0);
    step();
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5);
    get_resp(d, t, c);
    chk("rem_ovf_data", d, 32'd0);
    chk("ovf_starts", starts - s0, 0);
    step();

    resp_ready = 1'b0;
    send(OP_REMU, 32'd100, 32'd7, 4'd5);
    get_resp(d, t, c);
    chk("bp_data", d, 32'd2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_hold_data", resp_data, 32'd2);
      chk("bp_hold_tag", 32'(resp_tag), 5);
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(resp_valid), 1);
    chk("bp_hs_req_ready", 32'(req_ready), 0);
    step();
    @(negedge clk);
    chk("bp_after_valid", 32'(resp_valid), 0);
    chk("bp_after_req_ready", 32'(req_ready), 1);
    step();

    send(OP_DIV, 32'd1000, 32'd3, 4'd6);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (div_in_en) begin
        seen = 1;
        break;
      end
    end
    chk("fl_start_seen", 32'(seen), 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_drain_req_ready", 32'(req_ready), 0);
    chk("fl_drain_valid", 32'(resp_valid), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (div_out_en) begin
        seen = 1;
        break;
      end
      chk("fl_wait_valid", 32'(resp_valid), 0);
      @(negedge clk);
    end
    chk("fl_out_seen", 32'(seen), 1);
    chk("fl_out_req_ready", 32'(req_ready), 0);
    step();
    @(negedge clk);
    chk("fl_idle_req_ready", 32'(req_ready), 1);
    chk("fl_idle_valid", 32'(resp_valid), 0);
    step();
    send(OP_DIVU, 32'd9, 32'd3, 4'd7);
    get_resp(d, t, c);
    chk("fl_next_data", d, 32'd3);
    chk("fl_next_tag", 32'(t), 7);
    step();

    resp_ready = 1'b0;
    send(OP_DIVU, 32'd50, 32'd5, 4'd2);
    get_resp(d, t, c);
    chk("flr_data", d, 32'd10);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("flr_valid", 32'(resp_valid), 0);
    chk("flr_req_ready", 32'(req_ready), 1);
    step();

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 32'(resp_valid), 0);
    chk("rst2_req_ready", 32'(req_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    s0 = starts;
    send(OP_DIVU, 32'd100, 32'd7, 4'd8);
    get_resp(d, t, c);
    chk("c1_data", d, 32'd14);
    chk("c1_starts", starts - s0, 1);
    step();
    s0 = starts;
    send(OP_REMU, 32'd100, 32'd7, 4'd9);
    get_resp(d, t, c);
    chk("c2_data", d, 32'd2);
    chk("c2_tag", 32'(t), 9);
`ifdef DIV_RESULT_CACHE_EN
    chk("c2_lat", c, 0);
    chk("c2_starts", starts - s0, 0);
`else
    chk("c2_starts", starts - s0, 1);
`endif
    step();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
